// File: rtl/lorenz_encryptor_top.sv
// -----------------------------------------------------------------------------
// lorenz_encryptor_top
//   Byte-stream encryptor. Each accepted plaintext pixel is XORed with a key
//   byte and, when LORENZ_EN=1, with a chaotic byte taken from a Lorenz
//   attractor. The attractor is integrated in Q16.16 and steps once per
//   accepted pixel. Results, paired with the key byte that was used, are held
//   in a 2-entry output FIFO.
//
// Ports
//   clk, rst             : clock and synchronous active-high reset
//   s_axis_key_*         : key byte stream (consumed only together with a pixel)
//   s_axis_pixel_*       : plaintext pixel stream
//   m_axis_key_*         : echo of the key byte used for each cipher byte
//   m_axis_pixel_*       : ciphertext stream
//   done                 : sticky, set once FRAME_BYTES bytes have left the FIFO
// -----------------------------------------------------------------------------
module lorenz_encryptor_top #(
   parameter int unsigned FRAME_BYTES = 786432,
   parameter bit          LORENZ_EN   = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s_axis_key_tdata,
   input  logic       s_axis_key_tvalid,
   output logic       s_axis_key_tready,
   output logic [7:0] m_axis_key_tdata,
   output logic       m_axis_key_tvalid,
   input  logic       m_axis_key_tready,
   input  logic [7:0] s_axis_pixel_tdata,
   input  logic       s_axis_pixel_tvalid,
   output logic       s_axis_pixel_tready,
   output logic [7:0] m_axis_pixel_tdata,
   output logic       m_axis_pixel_tvalid,
   input  logic       m_axis_pixel_tready,
   output logic       done
);

   localparam logic signed [31:0] INIT_Q16   = 32'sh0001_0000;
   localparam logic signed [31:0] R_Q16      = 32'sh001C_0000;
   localparam logic signed [31:0] B_Q16      = 32'sh0002_AAAB;
   localparam logic        [31:0] FRAME_LAST = 32'(FRAME_BYTES - 1);

   logic signed [31:0] x_q, x_d, y_q, y_d, z_q, z_d;
   logic [7:0]         last_key_q, last_key_d;
   logic [15:0]        ent0_q, ent0_d, ent1_q, ent1_d;
   logic [1:0]         count_q, count_d;
   logic [31:0]        acc_cnt_q, acc_cnt_d, pop_cnt_q, pop_cnt_d;
   logic               frame_acc_q, frame_acc_d;
   logic               done_q, done_d;
   logic               ready_q, ready_d;

   logic               accept, pop;
   logic [7:0]         key_use, chaos;
   logic [15:0]        push_data;
   logic signed [31:0] rz, dx, dy, dz;
   logic [63:0]        p_xr, p_xy, p_bz;
   logic               unused_bits;

   assign accept = s_axis_pixel_tvalid && ready_q;
   assign pop    = (count_q != 2'd0) && m_axis_pixel_tready && m_axis_key_tready;

   // Lorenz derivative terms. Products are formed on sign-extended operands so
   // a plain 64-bit multiply yields the signed product; Q16.16 result is [47:16].
   always_comb begin
      rz   = R_Q16 - z_q;
      p_xr = {{32{x_q[31]}}, x_q} * {{32{rz[31]}}, rz};
      p_xy = {{32{x_q[31]}}, x_q} * {{32{y_q[31]}}, y_q};
      p_bz = {{32{B_Q16[31]}}, B_Q16} * {{32{z_q[31]}}, z_q};
      dx   = (y_q - x_q) * 32'sd10;
      dy   = $signed(p_xr[47:16]) - y_q;
      dz   = $signed(p_xy[47:16]) - $signed(p_bz[47:16]);
   end

   assign unused_bits = ^{p_xr[63:48], p_xr[15:0], p_xy[63:48], p_xy[15:0],
                          p_bz[63:48], p_bz[15:0]};

   always_comb begin
      key_use   = s_axis_key_tvalid ? s_axis_key_tdata : last_key_q;
      chaos     = LORENZ_EN ? (x_q[23:16] ^ y_q[23:16] ^ z_q[23:16]) : 8'h00;
      push_data = {s_axis_pixel_tdata ^ key_use ^ chaos, key_use};
   end

   always_comb begin
      x_d         = x_q;
      y_d         = y_q;
      z_d         = z_q;
      last_key_d  = last_key_q;
      acc_cnt_d   = acc_cnt_q;
      frame_acc_d = frame_acc_q;
      pop_cnt_d   = pop_cnt_q;
      done_d      = done_q;
      count_d     = count_q;
      ent0_d      = ent0_q;
      ent1_d      = ent1_q;

      if (accept) begin
         x_d        = x_q + (dx >>> 8);
         y_d        = y_q + (dy >>> 8);
         z_d        = z_q + (dz >>> 8);
         last_key_d = key_use;
         acc_cnt_d  = acc_cnt_q + 32'd1;
         if (acc_cnt_q == FRAME_LAST) frame_acc_d = 1'b1;
      end

      if (pop) begin
         pop_cnt_d = pop_cnt_q + 32'd1;
         if (pop_cnt_q == FRAME_LAST) done_d = 1'b1;
      end

      // Head always lives in ent0: pop shifts ent1 down first, then a push
      // lands in the first free slot of the post-pop occupancy.
      if (pop) begin
         ent0_d  = ent1_q;
         count_d = count_q - 2'd1;
      end
      if (accept) begin
         if (count_d == 2'd0) ent0_d = push_data;
         else                 ent1_d = push_data;
         count_d = count_d + 2'd1;
      end

      // Registered ready is derived from next-state so it always equals
      // (count < 2) && !frame_accepted of the current cycle.
      ready_d = (count_d != 2'd2) && !frame_acc_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q         <= INIT_Q16;
         y_q         <= INIT_Q16;
         z_q         <= INIT_Q16;
         last_key_q  <= '0;
         acc_cnt_q   <= '0;
         frame_acc_q <= 1'b0;
         pop_cnt_q   <= '0;
         done_q      <= 1'b0;
         count_q     <= '0;
         ent0_q      <= '0;
         ent1_q      <= '0;
         ready_q     <= 1'b1;
      end else begin
         x_q         <= x_d;
         y_q         <= y_d;
         z_q         <= z_d;
         last_key_q  <= last_key_d;
         acc_cnt_q   <= acc_cnt_d;
         frame_acc_q <= frame_acc_d;
         pop_cnt_q   <= pop_cnt_d;
         done_q      <= done_d;
         count_q     <= count_d;
         ent0_q      <= ent0_d;
         ent1_q      <= ent1_d;
         ready_q     <= ready_d;
      end
   end

   assign s_axis_key_tready   = ready_q;
   assign s_axis_pixel_tready = ready_q;
   assign m_axis_pixel_tvalid = (count_q != 2'd0);
   assign m_axis_key_tvalid   = (count_q != 2'd0);
   assign m_axis_pixel_tdata  = ent0_q[15:8];
   assign m_axis_key_tdata    = ent0_q[7:0];
   assign done                = done_q;

endmodule

// File: tb/tb_lorenz_encryptor_top.sv
// Bench for lorenz_encryptor_top. Lane 0 runs with the chaotic mixer enabled,
// lane 1 with plain key XOR and a 4-byte frame. A transaction-level model
// (queue FIFO, integer Lorenz arithmetic) predicts every output each cycle.
module tb_lorenz_encryptor_top;

   localparam int unsigned FB0 = 48;
   localparam int unsigned FB1 = 4;
   localparam int          R_Q = 32'h001C_0000;
   localparam int          B_Q = 32'h0002_AAAB;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst       [2];
   logic [7:0] kd        [2];
   logic [7:0] pd        [2];
   logic       kv        [2];
   logic       pv        [2];
   logic       mpr       [2];
   logic       mkr_drv   [2];
   logic       loop_key  [2];
   logic       mkr       [2];
   logic       s_key_rdy [2];
   logic       s_pix_rdy [2];
   logic       m_key_v   [2];
   logic       m_pix_v   [2];
   logic [7:0] m_key_d   [2];
   logic [7:0] m_pix_d   [2];
   logic       done      [2];

   assign mkr[0] = loop_key[0] ? s_key_rdy[0] : mkr_drv[0];
   assign mkr[1] = loop_key[1] ? s_key_rdy[1] : mkr_drv[1];

   lorenz_encryptor_top #(.FRAME_BYTES(FB0), .LORENZ_EN(1'b1)) u_dut_chaos (
      .clk(clk), .rst(rst[0]),
      .s_axis_key_tdata(kd[0]), .s_axis_key_tvalid(kv[0]), .s_axis_key_tready(s_key_rdy[0]),
      .m_axis_key_tdata(m_key_d[0]), .m_axis_key_tvalid(m_key_v[0]), .m_axis_key_tready(mkr[0]),
      .s_axis_pixel_tdata(pd[0]), .s_axis_pixel_tvalid(pv[0]), .s_axis_pixel_tready(s_pix_rdy[0]),
      .m_axis_pixel_tdata(m_pix_d[0]), .m_axis_pixel_tvalid(m_pix_v[0]), .m_axis_pixel_tready(mpr[0]),
      .done(done[0])
   );

   lorenz_encryptor_top #(.FRAME_BYTES(FB1), .LORENZ_EN(1'b0)) u_dut_plain (
      .clk(clk), .rst(rst[1]),
      .s_axis_key_tdata(kd[1]), .s_axis_key_tvalid(kv[1]), .s_axis_key_tready(s_key_rdy[1]),
      .m_axis_key_tdata(m_key_d[1]), .m_axis_key_tvalid(m_key_v[1]), .m_axis_key_tready(mkr[1]),
      .s_axis_pixel_tdata(pd[1]), .s_axis_pixel_tvalid(pv[1]), .s_axis_pixel_tready(s_pix_rdy[1]),
      .m_axis_pixel_tdata(m_pix_d[1]), .m_axis_pixel_tvalid(m_pix_v[1]), .m_axis_pixel_tready(mpr[1]),
      .done(done[1])
   );

   // ---------------- reference model ----------------
   int          mx [2];
   int          my [2];
   int          mz [2];
   logic [7:0]  mlast [2];
   logic [15:0] mq [2][$];
   logic [15:0] obs [2][$];
   int unsigned macc [2];
   int unsigned mpop [2];
   logic        mdone [2];
   int unsigned fb [2];
   bit          en [2];
   logic        acc_now [2];
   logic        pop_now [2];
   bit          chk_en;
   int          tests = 0;
   int          fails = 0;

   task automatic check(input string tag, input logic [15:0] obs_v, input logic [15:0] exp_v);
      tests++;
      assert (obs_v === exp_v) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs_v, exp_v);
      end
   endtask

   function automatic int qmul(input int a, input int b);
      longint p;
      p = longint'(a) * longint'(b);
      return int'(p >>> 16);
   endfunction

   function automatic logic exp_rdy(input int l);
      return (mq[l].size() < 2) && (macc[l] < fb[l]);
   endfunction

   task automatic lorenz_step(input int l);
      int x, y, z, dx, dy, dz;
      x  = mx[l]; y = my[l]; z = mz[l];
      dx = 10 * (y - x);
      dy = qmul(x, R_Q - z) - y;
      dz = qmul(x, y) - qmul(B_Q, z);
      mx[l] = x + (dx >>> 8);
      my[l] = y + (dy >>> 8);
      mz[l] = z + (dz >>> 8);
   endtask

   task automatic cycle();
      logic        r;
      logic [7:0]  k, c;
      logic [31:0] t;
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
         r = exp_rdy(l);
         if (chk_en) begin
            check($sformatf("l%0d_pix_ready", l), 16'(s_pix_rdy[l]), 16'(r));
            check($sformatf("l%0d_key_ready", l), 16'(s_key_rdy[l]), 16'(r));
            check($sformatf("l%0d_pix_valid", l), 16'(m_pix_v[l]), 16'(mq[l].size() != 0));
            check($sformatf("l%0d_key_valid", l), 16'(m_key_v[l]), 16'(mq[l].size() != 0));
            check($sformatf("l%0d_done", l), 16'(done[l]), 16'(mdone[l]));
            if (mq[l].size() != 0)
               check($sformatf("l%0d_head", l), {m_pix_d[l], m_key_d[l]}, mq[l][0]);
         end
         acc_now[l] = pv[l] && r && !rst[l];
         pop_now[l] = (mq[l].size() != 0) && mpr[l] && mkr[l] && !rst[l];
         if (pop_now[l]) obs[l].push_back({m_pix_d[l], m_key_d[l]});
      end
      @(posedge clk);
      for (int l = 0; l < 2; l++) begin
         if (rst[l]) begin
            mq[l].delete();
            macc[l] = 0; mpop[l] = 0; mdone[l] = 1'b0; mlast[l] = 8'h00;
            mx[l] = 32'h0001_0000; my[l] = 32'h0001_0000; mz[l] = 32'h0001_0000;
         end else begin
            if (pop_now[l]) begin
               void'(mq[l].pop_front());
               mpop[l]++;
               if (mpop[l] == fb[l]) mdone[l] = 1'b1;
            end
            if (acc_now[l]) begin
               k = kv[l] ? kd[l] : mlast[l];
               mlast[l] = k;
               t = 32'(mx[l] ^ my[l] ^ mz[l]);
               c = en[l] ? t[23:16] : 8'h00;
               mq[l].push_back({pd[l] ^ k ^ c, k});
               lorenz_step(l);
               macc[l]++;
            end
         end
      end
      #1;
   endtask

   task automatic set_in(input int l, input logic p_valid, input logic [7:0] p, input logic k_valid, input logic [7:0] k);
      pv[l] = p_valid; pd[l] = p; kv[l] = k_valid; kd[l] = k;
   endtask

   initial begin
      int n;
      fb[0] = FB0; fb[1] = FB1; en[0] = 1'b1; en[1] = 1'b0;
      for (int l = 0; l < 2; l++) begin
         rst[l] = 1'b1; set_in(l, 1'b0, 8'h00, 1'b0, 8'h00);
         mpr[l] = 1'b1; mkr_drv[l] = 1'b1; loop_key[l] = 1'b0;
         macc[l] = 0; mpop[l] = 0; mdone[l] = 1'b0;
      end
      chk_en = 1'b0;
      cycle();
      chk_en = 1'b1;
      cycle();
      for (int l = 0; l < 2; l++) begin
         check($sformatf("l%0d_rst_pix_data", l), 16'(m_pix_d[l]), 16'h0000);
         check($sformatf("l%0d_rst_key_data", l), 16'(m_key_d[l]), 16'h0000);
         check($sformatf("l%0d_rst_ready", l), 16'(s_pix_rdy[l]), 16'h0001);
         rst[l] = 1'b0;
      end
      cycle();

      // Plain XOR, one-cycle latency
      set_in(1, 1'b1, 8'h3C, 1'b1, 8'hA5);
      cycle();
      check("l1_latency_valid", 16'(m_pix_v[1]), 16'h0001);
      check("l1_first_cipher", {m_pix_d[1], m_key_d[1]}, 16'h99A5);
      set_in(1, 1'b1, 8'hFF, 1'b1, 8'h0F);
      cycle();
      check("l1_second_cipher", {m_pix_d[1], m_key_d[1]}, 16'hF00F);
      set_in(1, 1'b0, 8'h00, 1'b0, 8'h00);
      cycle(); cycle();

      // Key valid dropped: last key reused
      set_in(1, 1'b1, 8'h00, 1'b1, 8'h5A);
      cycle();
      set_in(1, 1'b1, 8'h11, 1'b0, 8'hEE);
      cycle();
      set_in(1, 1'b0, 8'h00, 1'b0, 8'h00);
      cycle(); cycle();
      check("l1_obs_count", 16'(obs[1].size()), 16'd4);
      if (obs[1].size() == 4) begin
         check("l1_obs0", obs[1][0], 16'h99A5);
         check("l1_obs1", obs[1][1], 16'hF00F);
         check("l1_obs2", obs[1][2], 16'h5A5A);
         check("l1_obs3", obs[1][3], 16'h4B5A);
      end
      check("l1_done_after_frame", 16'(done[1]), 16'h0001);

      // Frame complete: further pixels refused
      set_in(1, 1'b1, 8'h77, 1'b1, 8'h01);
      repeat (4) cycle();
      check("l1_ready_low_after_frame", 16'(s_pix_rdy[1]), 16'h0000);
      check("l1_no_extra_output", 16'(obs[1].size()), 16'd4);
      set_in(1, 1'b0, 8'h00, 1'b0, 8'h00);
      rst[1] = 1'b1;
      cycle();
      rst[1] = 1'b0;
      check("l1_done_cleared", 16'(done[1]), 16'h0000);
      check("l1_ready_after_rst", 16'(s_pix_rdy[1]), 16'h0001);
      cycle();

      // Chaotic keystream from reset
      set_in(0, 1'b1, 8'h00, 1'b1, 8'h00);
      cycle(); cycle();
      set_in(0, 1'b0, 8'h00, 1'b0, 8'h00);
      cycle(); cycle();
      check("l0_obs_count", 16'(obs[0].size()), 16'd2);
      if (obs[0].size() == 2) begin
         check("l0_chaos_step1", obs[0][0], 16'h0100);
         check("l0_chaos_step2", obs[0][1], 16'h0000);
      end

      // Backpressure with key ready looped to key tready
      mpr[0] = 1'b0; loop_key[0] = 1'b1;
      set_in(0, 1'b1, 8'hA1, 1'b1, 8'h11);
      cycle();
      set_in(0, 1'b1, 8'hB2, 1'b1, 8'h22);
      cycle();
      set_in(0, 1'b1, 8'hC3, 1'b1, 8'h33);
      cycle(); cycle();
      check("l0_ready_low_full", 16'(s_pix_rdy[0]), 16'h0000);
      check("l0_valid_held", 16'(m_pix_v[0]), 16'h0001);
      mpr[0] = 1'b1; loop_key[0] = 1'b0; mkr_drv[0] = 1'b1;
      n = 0;
      do begin cycle(); n++; end while (!acc_now[0] && n < 8);
      set_in(0, 1'b0, 8'h00, 1'b0, 8'h00);
      repeat (4) cycle();
      check("l0_bp_obs_count", 16'(obs[0].size()), 16'd5);
      if (obs[0].size() == 5) begin
         check("l0_bp_order0", 16'(obs[0][2][7:0]), 16'h0011);
         check("l0_bp_order1", 16'(obs[0][3][7:0]), 16'h0022);
         check("l0_bp_order2", 16'(obs[0][4][7:0]), 16'h0033);
      end

      // Reset mid-frame with full FIFO
      mpr[0] = 1'b0;
      set_in(0, 1'b1, 8'h05, 1'b1, 8'h06);
      cycle();
      set_in(0, 1'b1, 8'h07, 1'b1, 8'h08);
      cycle();
      set_in(0, 1'b0, 8'h00, 1'b0, 8'h00);
      check("l0_full_before_rst", 16'(s_pix_rdy[0]), 16'h0000);
      rst[0] = 1'b1;
      cycle();
      rst[0] = 1'b0;
      check("l0_valid_cleared", 16'(m_pix_v[0]), 16'h0000);
      check("l0_key_valid_cleared", 16'(m_key_v[0]), 16'h0000);
      mpr[0] = 1'b1;
      set_in(0, 1'b1, 8'h00, 1'b1, 8'h00);
      cycle();
      set_in(0, 1'b0, 8'h00, 1'b0, 8'h00);
      check("l0_restart_cipher", {m_pix_d[0], m_key_d[0]}, 16'h0100);
      cycle(); cycle();

      // Randomized traffic through a full frame
      rst[0] = 1'b1;
      cycle();
      rst[0] = 1'b0;
      for (int i = 0; i < 3000 && !mdone[0]; i++) begin
         set_in(0, $urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
         mpr[0]     = ($urandom_range(0, 3) != 0);
         mkr_drv[0] = ($urandom_range(0, 3) != 0);
         cycle();
      end
      set_in(0, 1'b0, 8'h00, 1'b0, 8'h00);
      mpr[0] = 1'b1; mkr_drv[0] = 1'b1;
      cycle(); cycle();
      check("l0_random_done", 16'(done[0]), 16'h0001);
      check("l0_random_ready_low", 16'(s_pix_rdy[0]), 16'h0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lorenz_encryptor_top.md
LORENZ_ENCRYPTOR_TOP -- requirements
Module: lorenz_encryptor_top

Interface
REQ-001 Parameters (name, default, meaning): FRAME_BYTES, 786432, pixel bytes per frame (512x512x3); LORENZ_EN, 1, 1 = mix chaotic byte into cipher, 0 = plain key XOR.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axis_key_tdata  in  8  key byte.
- s_axis_key_tvalid  in  1  key byte valid.
- s_axis_key_tready  out  1  block can accept key.
- m_axis_key_tdata  out  8  echo of key byte used for the paired pixel.
- m_axis_key_tvalid  out  1  key echo valid.
- m_axis_key_tready  in  1  key consumer ready.
- s_axis_pixel_tdata  in  8  plaintext pixel byte.
- s_axis_pixel_tvalid  in  1  pixel valid.
- s_axis_pixel_tready  out  1  block can accept pixel.
- m_axis_pixel_tdata  out  8  ciphertext byte.
- m_axis_pixel_tvalid  out  1  ciphertext valid.
- m_axis_pixel_tready  in  1  ciphertext consumer ready.
- done  out  1  sticky frame-complete flag.

Function
REQ-003 Both s_axis_*_tready SHALL be driven from registers only, equal to (fifo_count<2) && !frame_accepted; no combinational path from any m_axis_*_tready (a consumer may tie m_axis_key_tready to s_axis_key_tready).
REQ-004 s_axis_key_tready SHALL equal s_axis_pixel_tready every cycle.
REQ-005 Accept event: s_axis_pixel_tvalid && s_axis_pixel_tready; key consumed in the same cycle if s_axis_key_tvalid, else last accepted key (reset 0x00) reused; key without pixel never consumed.
REQ-006 Per accept: cipher = pixel XOR key XOR C, C = x[23:16]^y[23:16]^z[23:16] of current Lorenz state when LORENZ_EN=1, else C=0x00.
REQ-007 Lorenz state x,y,z: signed 32-bit Q16.16, reset value 0x00010000 each (1.0).
REQ-008 Lorenz update on each accept only, all from old values simultaneously: dx=10*(y-x); dy=x*(R-z)-y; dz=x*y-B*z; x+=dx>>>8, y+=dy>>>8, z+=dz>>>8 (dt=1/256, arithmetic shift).
REQ-009 Constants: R=0x001C0000 (28.0), B=0x0002AAAB (~8/3); products 32x32 signed to 64-bit, result bits [47:16]; all sums two's-complement wrap at 32 bits, no saturation.
REQ-010 Output: 2-entry FIFO of {cipher, key}; push on accept; m_axis_pixel_tvalid = m_axis_key_tvalid = (count!=0); data = head entry.
REQ-011 Pop when count!=0 && m_axis_pixel_tready && m_axis_key_tready; simultaneous push and pop at count=1 keeps count=1, order preserved.
REQ-012 Latency: byte accepted in cycle N SHALL appear on m_axis_* in cycle N+1 when FIFO was empty.
REQ-013 Output data SHALL be held stable while valid && !(both readies).
REQ-014 Accept counter SHALL set frame_accepted after FRAME_BYTES accepts; pop counter SHALL assert done the cycle after the FRAME_BYTES-th pop; done stays high until reset.
REQ-015 After frame_accepted, tready stays low; Lorenz state frozen.

Reset
REQ-016 With rst high at a clock edge: FIFO emptied, all m_axis_*_tvalid=0, m_axis_*_tdata=0x00, done=0, counters=0, last key=0x00, x=y=z=0x00010000; s_axis_*_tready=1 from the cycle after rst falls.
REQ-017 Reset mid-frame SHALL discard FIFO contents and restart the keystream from the initial state.

Verification
REQ-018 LORENZ_EN=0, pixels 0x3C,0xFF with keys 0xA5,0x0F, consumer ready -> outputs 0x99,0xF0, key echo 0xA5,0x0F, one cycle latency.
REQ-019 LORENZ_EN=1 from reset, pixels 0x00,0x00 keys 0x00,0x00 -> ciphertext 0x01 then 0x00 (state after step 1: x=0x00010000, y=0x00011A00, z=0x0000FE55).
REQ-020 m_axis_pixel_tready=0 with key ready looped to s_axis_key_tready, 3 pixels offered -> 2 accepted, tready falls, no loop; release -> bytes in order, third then accepted.
REQ-021 Key tvalid dropped after first pixel (key 0x5A), LORENZ_EN=0, pixels 0x00,0x11 -> outputs 0x5A,0x4B.
REQ-022 FRAME_BYTES=4, 5 pixels offered -> 4 accepted, tready stays low, done high cycle after 4th pop; rst -> done=0, tready=1.
REQ-023 rst asserted mid-frame with FIFO full -> tvalid=0 next cycle; next pixel 0x00 key 0x00 -> 0x01.
